// File: rtl/downscale_fetch_sequencer_if.sv
// Read-port and interpolation-bundle handshakes of the downscale fetch sequencer.
// master = sequencer side, slave = frame memory / interpolation pipeline side.
interface downscale_fetch_sequencer_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 8
);
  logic              o_rd_req;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              i_rd_ack;
  logic [PIX_W-1:0]  i_rd_data;
  logic [PIX_W-1:0]  o_p00, o_p01, o_p10, o_p11;
  logic [15:0]       o_wx_q, o_wy_q;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output o_rd_req, o_rd_addr, o_p00, o_p01, o_p10, o_p11, o_wx_q, o_wy_q, o_valid,
    input  i_rd_ack, i_rd_data, i_ready
  );
  modport slave (
    input  o_rd_req, o_rd_addr, o_p00, o_p01, o_p10, o_p11, o_wx_q, o_wy_q, o_valid,
    output i_rd_ack, i_rd_data, i_ready
  );
endinterface

// File: rtl/downscale_fetch_sequencer.sv
// Bilinear downscale sequencer: walks output pixels, fetches 4 neighbours, issues bundles.
// Optional DS_SEQ_PERF_EN adds o_stall_cnt (saturating count of handshake stall cycles).
module downscale_fetch_sequencer #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 20,
  parameter int PIX_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_src_w,
  input  logic [COORD_W-1:0] i_src_h,
  input  logic [COORD_W-1:0] i_dst_w,
  input  logic [COORD_W-1:0] i_dst_h,
  input  logic [15:0]        i_step_q,
  output logic               o_busy,
  output logic               o_done,
  downscale_fetch_sequencer_if.master bus
`ifdef DS_SEQ_PERF_EN
  ,
  output logic [31:0]        o_stall_cnt
`endif
);
  localparam int ACC_W = COORD_W + 8;
  localparam logic [COORD_W:0]   ONE_C = 1;
  localparam logic [COORD_W-1:0] ONE_O = 1;

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, ISSUE, DONE} state_t;
  typedef struct packed {
    logic [COORD_W-1:0] src_w, src_h, dst_w, dst_h;
    logic [15:0]        step;
  } cfg_t;

  state_t                state;
  cfg_t                  cfg;
  logic [COORD_W-1:0]    ox, oy;
  logic [ACC_W-1:0]      x_acc, y_acc, nx_acc, ny_acc, step_ext;
  logic [1:0]            idx;
  logic [3:0][PIX_W-1:0] pix;
  logic                  row_end, last;

  // sel[0] picks x1 over x0, sel[1] picks y1 over y0; both clamp to the source edge
  function automatic logic [ADDR_W-1:0] nbr_addr(input logic [1:0] sel,
      input logic [ACC_W-1:0] xa, input logic [ACC_W-1:0] ya,
      input logic [COORD_W-1:0] sw, input logic [COORD_W-1:0] sh);
    logic [COORD_W:0]  xm, ym, xi, yi;
    logic [ADDR_W-1:0] row;
    xm = {1'b0, sw} - ONE_C;
    ym = {1'b0, sh} - ONE_C;
    xi = {1'b0, xa[ACC_W-1:8]};
    yi = {1'b0, ya[ACC_W-1:8]};
    if (xi > xm) xi = xm;
    if (yi > ym) yi = ym;
    if (sel[0]) xi = (xi + ONE_C > xm) ? xm : xi + ONE_C;
    if (sel[1]) yi = (yi + ONE_C > ym) ? ym : yi + ONE_C;
    row = ADDR_W'(yi) * ADDR_W'(sw);
    return row + ADDR_W'(xi);
  endfunction

  assign step_ext = ACC_W'(cfg.step);
  assign row_end  = (ox == cfg.dst_w - ONE_O);
  assign last     = row_end && (oy == cfg.dst_h - ONE_O);
  assign nx_acc   = row_end ? '0 : x_acc + step_ext;
  assign ny_acc   = row_end ? y_acc + step_ext : y_acc;

  assign bus.o_p00 = pix[0];
  assign bus.o_p01 = pix[1];
  assign bus.o_p10 = pix[2];
  assign bus.o_p11 = pix[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cfg           <= '0;
      ox            <= '0;
      oy            <= '0;
      x_acc         <= '0;
      y_acc         <= '0;
      idx           <= '0;
      pix           <= '0;
      bus.o_rd_req  <= 1'b0;
      bus.o_rd_addr <= '0;
      bus.o_wx_q    <= '0;
      bus.o_wy_q    <= '0;
      bus.o_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state  <= SETUP;
          o_busy <= 1'b1;
        end
        SETUP: begin
          cfg   <= '{src_w: i_src_w, src_h: i_src_h, dst_w: i_dst_w, dst_h: i_dst_h, step: i_step_q};
          ox    <= '0;
          oy    <= '0;
          x_acc <= '0;
          y_acc <= '0;
          idx   <= '0;
          if (i_dst_w == '0 || i_dst_h == '0) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            state         <= FETCH;
            bus.o_rd_req  <= 1'b1;
            bus.o_rd_addr <= nbr_addr(2'd0, '0, '0, i_src_w, i_src_h);
          end
        end
        FETCH: if (bus.i_rd_ack) begin
          pix[idx] <= bus.i_rd_data;
          if (idx == 2'd3) begin
            state        <= ISSUE;
            bus.o_rd_req <= 1'b0;
            bus.o_valid  <= 1'b1;
            bus.o_wx_q   <= {8'h00, x_acc[7:0]};
            bus.o_wy_q   <= {8'h00, y_acc[7:0]};
          end else begin
            idx           <= idx + 2'd1;
            bus.o_rd_addr <= nbr_addr(idx + 2'd1, x_acc, y_acc, cfg.src_w, cfg.src_h);
          end
        end
        ISSUE: if (bus.i_ready) begin
          bus.o_valid <= 1'b0;
          idx         <= '0;
          if (last) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            // first address of the next pixel comes from the post-advance accumulators
            state         <= FETCH;
            ox            <= row_end ? '0 : ox + ONE_O;
            oy            <= row_end ? oy + ONE_O : oy;
            x_acc         <= nx_acc;
            y_acc         <= ny_acc;
            bus.o_rd_req  <= 1'b1;
            bus.o_rd_addr <= nbr_addr(2'd0, nx_acc, ny_acc, cfg.src_w, cfg.src_h);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DS_SEQ_PERF_EN
  logic stall;
  assign stall = (bus.o_rd_req && !bus.i_rd_ack) || (bus.o_valid && !bus.i_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               o_stall_cnt <= '0;
    else if (state == SETUP)                  o_stall_cnt <= '0;
    else if (stall && o_stall_cnt != '1)      o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_downscale_fetch_sequencer.sv
// Directed bench for downscale_fetch_sequencer: memory responder with programmable ack
// delay, pipeline sink with programmable backpressure, hand-computed address/weight tables.
module tb_downscale_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  src_w, src_h, dst_w, dst_h;
  logic [15:0] step;
  logic        busy, done;
`ifdef DS_SEQ_PERF_EN
  logic [31:0] stall_cnt;
`endif

  downscale_fetch_sequencer_if #(.ADDR_W(20), .PIX_W(8)) bus();

  downscale_fetch_sequencer #(.COORD_W(10), .ADDR_W(20), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start),
    .i_src_w(src_w), .i_src_h(src_h), .i_dst_w(dst_w), .i_dst_h(dst_h),
    .i_step_q(step), .o_busy(busy), .o_done(done), .bus(bus)
`ifdef DS_SEQ_PERF_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] memf(input logic [19:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd37 + 32'd11;
    return t[7:0];
  endfunction

  // responder / sink state (written only by the negedge process below)
  logic [19:0] addr_q[$];
  logic [63:0] bnd_q[$];
  int          wcnt = 0, vcnt = 0, bif = 0;
  int          stab_a = 0, stab_b = 0, ack_waits = 0, rdy_waits = 0, done_cnt = 0;
  bit          have_a = 0, have_b = 0;
  logic [19:0] held_a;
  logic [63:0] held_b, cur;
  logic [31:0] stall_snap = '0;

  // knobs (written only by the main initial block)
  int ack_delay = 0;
  int rdy_hold  = 0;
  int base_a, base_b, base_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.i_rd_ack = 1'b0;
      bus.i_ready  = 1'b1;
      wcnt = 0; vcnt = 0; bif = 0; have_a = 0; have_b = 0;
    end else begin
      if (!busy) begin vcnt = 0; bif = 0; end
      if (bus.o_rd_req) begin
        if (have_a && bus.o_rd_addr !== held_a) stab_a++;
        if (wcnt >= ack_delay) begin
          bus.i_rd_ack  = 1'b1;
          bus.i_rd_data = memf(bus.o_rd_addr);
          addr_q.push_back(bus.o_rd_addr);
          wcnt = 0; have_a = 0;
        end else begin
          bus.i_rd_ack = 1'b0;
          wcnt++; ack_waits++; have_a = 1; held_a = bus.o_rd_addr;
        end
      end else begin
        bus.i_rd_ack = 1'b0; wcnt = 0; have_a = 0;
      end
      if (bus.o_valid) begin
        cur = {bus.o_p00, bus.o_p01, bus.o_p10, bus.o_p11, bus.o_wx_q, bus.o_wy_q};
        if (have_b && cur !== held_b) stab_b++;
        if (bif == 0 && vcnt < rdy_hold) begin
          bus.i_ready = 1'b0;
          vcnt++; rdy_waits++; have_b = 1; held_b = cur;
        end else begin
          bus.i_ready = 1'b1;
          bnd_q.push_back(cur);
          bif++; have_b = 0;
`ifdef DS_SEQ_PERF_EN
          if (bif == 1) stall_snap = stall_cnt;
`endif
        end
      end else begin
        bus.i_ready = 1'b1; have_b = 0;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_frame(input logic [9:0] sw, input logic [9:0] sh, input logic [9:0] dw,
                           input logic [9:0] dh, input logic [15:0] st, input bit mid);
    int n;
    src_w = sw; src_h = sh; dst_w = dw; dst_h = dh; step = st;
    base_a = addr_q.size(); base_b = bnd_q.size(); base_d = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (mid && n == 8) start = 1'b1;
      if (mid && n == 9) start = 1'b0;
    end
    if (n >= 3000) chk("frame_timeout", 64'(n), 64'(0));
    @(negedge clk);
    chk("busy_fall", 64'(busy), 64'(0));
  endtask

  task automatic chk_px(input string tag, input int k, input logic [19:0] a0, input logic [19:0] a1,
                        input logic [19:0] a2, input logic [19:0] a3, input logic [15:0] wx,
                        input logic [15:0] wy);
    int i, j;
    i = base_b + k;
    j = base_a + 4 * k;
    if (i >= bnd_q.size() || j + 3 >= addr_q.size()) begin
      chk({tag, "_missing"}, 64'(0), 64'(1));
    end else begin
      chk({tag, "_addr"}, {16'(addr_q[j]), 16'(addr_q[j+1]), 16'(addr_q[j+2]), 16'(addr_q[j+3])},
          {16'(a0), 16'(a1), 16'(a2), 16'(a3)});
      chk({tag, "_bundle"}, bnd_q[i], {memf(a0), memf(a1), memf(a2), memf(a3), wx, wy});
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    src_w = '0; src_h = '0; dst_w = '0; dst_h = '0; step = '0;
    bus.i_rd_ack = 1'b0; bus.i_rd_data = '0; bus.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_req",   64'(bus.o_rd_req), 64'(0));
    chk("rst_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_data",  {bus.o_p00, bus.o_p01, bus.o_p10, bus.o_p11, bus.o_wx_q, bus.o_wy_q}, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 4x4 -> 2x2, step 2.0, no stalls
    run_frame(10'd4, 10'd4, 10'd2, 10'd2, 16'h0200, 1'b0);
    chk("t1_reads",   64'(addr_q.size() - base_a), 64'(16));
    chk("t1_bundles", 64'(bnd_q.size() - base_b), 64'(4));
    chk("t1_dones",   64'(done_cnt - base_d), 64'(1));
    chk_px("t1_px00", 0, 20'd0,  20'd1,  20'd4,  20'd5,  16'h0000, 16'h0000);
    chk_px("t1_px10", 1, 20'd2,  20'd3,  20'd6,  20'd7,  16'h0000, 16'h0000);
    chk_px("t1_px01", 2, 20'd8,  20'd9,  20'd12, 20'd13, 16'h0000, 16'h0000);
    chk_px("t1_px11", 3, 20'd10, 20'd11, 20'd14, 20'd15, 16'h0000, 16'h0000);

    // 3x3 -> 2x2, step 1.5: fractional weights
    run_frame(10'd3, 10'd3, 10'd2, 10'd2, 16'h0180, 1'b0);
    chk_px("t2_px00", 0, 20'd0, 20'd1, 20'd3, 20'd4, 16'h0000, 16'h0000);
    chk_px("t2_px10", 1, 20'd1, 20'd2, 20'd4, 20'd5, 16'h0080, 16'h0000);
    chk_px("t2_px11", 3, 20'd4, 20'd5, 20'd7, 20'd8, 16'h0080, 16'h0080);

    // 3x3 -> 2x2, step 2.0: right/bottom edge clamping
    run_frame(10'd3, 10'd3, 10'd2, 10'd2, 16'h0200, 1'b0);
    chk_px("t3_px10", 1, 20'd2, 20'd2, 20'd5, 20'd5, 16'h0000, 16'h0000);
    chk_px("t3_px01", 2, 20'd6, 20'd7, 20'd6, 20'd7, 16'h0000, 16'h0000);
    chk_px("t3_px11", 3, 20'd8, 20'd8, 20'd8, 20'd8, 16'h0000, 16'h0000);

    // backpressure: 3-cycle ack delay per read, ready low 5 cycles on the first bundle
    ack_delay = 3; rdy_hold = 5;
    n = ack_waits;
    base_a = rdy_waits;
    begin
      int rw0;
      rw0 = rdy_waits;
      run_frame(10'd4, 10'd4, 10'd2, 10'd2, 16'h0200, 1'b0);
      chk("t4_ack_waits", 64'(ack_waits - n), 64'(48));
      chk("t4_rdy_waits", 64'(rdy_waits - rw0), 64'(5));
    end
    chk("t4_addr_stable",   64'(stab_a), 64'(0));
    chk("t4_bundle_stable", 64'(stab_b), 64'(0));
    chk_px("t4_px00", 0, 20'd0,  20'd1,  20'd4,  20'd5,  16'h0000, 16'h0000);
    chk_px("t4_px11", 3, 20'd10, 20'd11, 20'd14, 20'd15, 16'h0000, 16'h0000);
`ifdef DS_SEQ_PERF_EN
    chk("t4_stall_cnt", 64'(stall_snap), 64'(17));
`endif
    ack_delay = 0; rdy_hold = 0;

    // empty output: done two cycles after start, no reads
    src_w = 10'd4; src_h = 10'd4; dst_w = 10'd0; dst_h = 10'd2; step = 16'h0200;
    base_a = addr_q.size(); base_d = done_cnt;
    @(negedge clk) start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 10);
    chk("t5_done_latency", 64'(n), 64'(2));
    @(negedge clk);
    chk("t5_busy_fall", 64'(busy), 64'(0));
    chk("t5_reads",     64'(addr_q.size() - base_a), 64'(0));
    chk("t5_dones",     64'(done_cnt - base_d), 64'(1));

    // start while busy is ignored
    run_frame(10'd4, 10'd4, 10'd2, 10'd2, 16'h0200, 1'b1);
    chk("t6_bundles", 64'(bnd_q.size() - base_b), 64'(4));
    chk("t6_dones",   64'(done_cnt - base_d), 64'(1));
    repeat (3) @(negedge clk);
    chk("t6_idle_after", 64'(busy), 64'(0));

    // reset during FETCH: outputs drop at once, next frame restarts from (0,0)
    ack_delay = 20;
    src_w = 10'd4; src_h = 10'd4; dst_w = 10'd2; dst_h = 10'd2; step = 16'h0200;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!bus.o_rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t7_req_seen", 64'(bus.o_rd_req), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_req_drop",   64'(bus.o_rd_req), 64'(0));
    chk("t7_valid_drop", 64'(bus.o_valid), 64'(0));
    chk("t7_busy_drop",  64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    run_frame(10'd4, 10'd4, 10'd2, 10'd2, 16'h0200, 1'b0);
    chk("t7_reads", 64'(addr_q.size() - base_a), 64'(16));
    chk_px("t7_px00", 0, 20'd0, 20'd1, 20'd4, 20'd5, 16'h0000, 16'h0000);
    chk_px("t7_px10", 1, 20'd2, 20'd3, 20'd6, 20'd7, 16'h0000, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
